// File: rtl/clk_speed_detector_if.sv
// ---------------------------------------------------------------------------
// clk_speed_detector_if
//   Bundles the monitored clock input and the measurement results of
//   clk_speed_detector.
//   master : drives ClkIn, observes the results (board / testbench side)
//   slave  : the detector itself
//   ClkIn     monitored slow clock, asynchronous to the system clock
//   EdgePulse one-cycle pulse per detected ClkIn rising edge
//   Period    last measured period in system clock cycles
//   SpeedDet  00 slow, 01 fast, 11 unknown
//   Valid     speed locked
//   Lost      sticky timeout flag, cleared by the next detected rising edge
// ---------------------------------------------------------------------------
interface clk_speed_detector_if #(
    parameter int CW = 27
);
    logic          ClkIn;
    logic          EdgePulse;
    logic [CW-1:0] Period;
    logic [1:0]    SpeedDet;
    logic          Valid;
    logic          Lost;

    modport master (
        output ClkIn,
        input  EdgePulse, Period, SpeedDet, Valid, Lost
    );

    modport slave (
        input  ClkIn,
        output EdgePulse, Period, SpeedDet, Valid, Lost
    );
endinterface

// File: rtl/clk_speed_detector.sv
// ---------------------------------------------------------------------------
// clk_speed_detector
//   Measures the period of a slow divided clock against Clk50MHz and
//   classifies it as slow (PERIOD_SLOW) or fast (PERIOD_FAST), with lock
//   and loss monitoring.
//   Clk50MHz  system clock, all registers on its rising edge
//   Rst       synchronous active-high reset
//   bus       clk_speed_detector_if slave (ClkIn in; EdgePulse, Period,
//             SpeedDet, Valid, Lost out)
// ---------------------------------------------------------------------------
module clk_speed_detector #(
    parameter int PERIOD_SLOW = 50_000_000,
    parameter int PERIOD_FAST = 10_000_000,
    parameter int TOL         = 500_000,
    parameter int TIMEOUT     = 75_000_000,
    parameter int CW          = 27
) (
    input  logic                  Clk50MHz,
    input  logic                  Rst,
    clk_speed_detector_if.slave   bus
);

    typedef enum logic {WAIT_FIRST, MEASURE} state_t;

    localparam logic [1:0]    CLS_SLOW = 2'b00;
    localparam logic [1:0]    CLS_FAST = 2'b01;
    localparam logic [1:0]    CLS_UNK  = 2'b11;

    localparam logic [CW-1:0] TMO    = TIMEOUT[CW-1:0];
    localparam logic [CW:0]   SLOW_X = PERIOD_SLOW[CW:0];
    localparam logic [CW:0]   FAST_X = PERIOD_FAST[CW:0];
    localparam logic [CW:0]   TOL_X  = TOL[CW:0];

    // Three-flop chain: s1/s2 resynchronise, s3 is the delayed copy for edge detect.
    logic          s1_q, s2_q, s3_q;
    logic          rise;

    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [CW-1:0] period_q, period_d;
    logic [1:0]    speed_q, speed_d;
    logic [1:0]    prev_q, prev_d;
    logic          valid_q, valid_d;
    logic          lost_q, lost_d;
    logic          pulse_q, pulse_d;

    logic [CW:0]   cnt_x, diff_slow, diff_fast;
    logic [1:0]    cls;

    assign rise = s2_q & ~s3_q;

    // Counter restarts at 1 on a rise so that it equals the rise spacing
    // on the cycle of the next rise; it parks at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (rise)
            cnt_d = {{(CW-1){1'b0}}, 1'b1};
        else if (cnt_q < TMO)
            cnt_d = cnt_q + 1'b1;
    end

    // One extra bit so the absolute difference can never wrap.
    always_comb begin
        cnt_x     = {1'b0, cnt_q};
        diff_slow = (cnt_x >= SLOW_X) ? cnt_x - SLOW_X : SLOW_X - cnt_x;
        diff_fast = (cnt_x >= FAST_X) ? cnt_x - FAST_X : FAST_X - cnt_x;
        if (diff_slow <= TOL_X)
            cls = CLS_SLOW;
        else if (diff_fast <= TOL_X)
            cls = CLS_FAST;
        else
            cls = CLS_UNK;
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        speed_d  = speed_q;
        prev_d   = prev_q;
        valid_d  = valid_q;
        lost_d   = lost_q;
        pulse_d  = 1'b0;
        case (state_q)
            WAIT_FIRST: begin
                // First edge only establishes a reference point.
                if (rise) begin
                    state_d = MEASURE;
                    lost_d  = 1'b0;
                    pulse_d = 1'b1;
                end
            end
            MEASURE: begin
                // A rise coinciding with the timeout count still counts as a rise.
                if (rise) begin
                    period_d = cnt_q;
                    speed_d  = cls;
                    valid_d  = (cls == prev_q) && (cls != CLS_UNK);
                    prev_d   = cls;
                    pulse_d  = 1'b1;
                end else if (cnt_q == TMO) begin
                    valid_d = 1'b0;
                    speed_d = CLS_UNK;
                    lost_d  = 1'b1;
                    prev_d  = CLS_UNK;
                    state_d = WAIT_FIRST;
                end
            end
        endcase
    end

    always_ff @(posedge Clk50MHz) begin
        if (Rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            state_q  <= WAIT_FIRST;
            period_q <= '0;
            speed_q  <= CLS_UNK;
            prev_q   <= CLS_UNK;
            valid_q  <= 1'b0;
            lost_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            s1_q     <= bus.ClkIn;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            period_q <= period_d;
            speed_q  <= speed_d;
            prev_q   <= prev_d;
            valid_q  <= valid_d;
            lost_q   <= lost_d;
            pulse_q  <= pulse_d;
        end
    end

    assign bus.EdgePulse = pulse_q;
    assign bus.Period    = period_q;
    assign bus.SpeedDet  = speed_q;
    assign bus.Valid     = valid_q;
    assign bus.Lost      = lost_q;

endmodule

// File: tb/tb_clk_speed_detector.sv
// ---------------------------------------------------------------------------
// tb_clk_speed_detector
//   Drives ClkIn as a sequence of rising edges with chosen spacings and
//   compares the detector outputs against an edge-level reference model.
// ---------------------------------------------------------------------------
module tb_clk_speed_detector;
    localparam int PS = 500, PF = 100, TL = 5, TO = 750, CW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clk_speed_detector_if #(.CW(CW)) bus();

    clk_speed_detector #(
        .PERIOD_SLOW(PS), .PERIOD_FAST(PF), .TOL(TL), .TIMEOUT(TO), .CW(CW)
    ) dut (
        .Clk50MHz(clk),
        .Rst     (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int since = 1000;   // negedges since ClkIn was last raised

    // Reference model, tracked per ClkIn rising edge.
    bit            m_meas;
    logic [CW-1:0] m_period;
    logic [1:0]    m_speed, m_prev;
    logic          m_valid, m_lost;

    logic [CW+4:0] obs;
    assign obs = {bus.EdgePulse, bus.Period, bus.SpeedDet, bus.Valid, bus.Lost};

    function automatic logic [CW+4:0] expv(input logic ep);
        return {ep, m_period, m_speed, m_valid, m_lost};
    endfunction

    function automatic logic [1:0] classify(input int p);
        int ds, df;
        ds = (p > PS) ? p - PS : PS - p;
        df = (p > PF) ? p - PF : PF - p;
        if (ds <= TL) return 2'b00;
        if (df <= TL) return 2'b01;
        return 2'b11;
    endfunction

    task automatic model_reset();
        m_meas = 0; m_period = '0; m_speed = 2'b11; m_prev = 2'b11;
        m_valid = 0; m_lost = 0;
    endtask

    // A gap longer than TIMEOUT means the loss fired before this edge.
    task automatic model_edge(input int gap);
        logic [1:0] c;
        if (m_meas && gap > TO) begin
            m_valid = 0; m_speed = 2'b11; m_lost = 1; m_prev = 2'b11; m_meas = 0;
        end
        if (!m_meas) begin
            m_meas = 1; m_lost = 0;
        end else begin
            c = classify(gap);
            m_period = gap[CW-1:0];
            m_speed  = c;
            m_valid  = (c == m_prev) && (c != 2'b11);
            m_prev   = c;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        since++;
        if (since == 3) bus.ClkIn = 1'b0;
    endtask

    task automatic raise(input int gap);
        while (since < gap) tick();
        model_edge(since);
        bus.ClkIn = 1'b1;
        since = 0;
    endtask

    // Raise ClkIn and advance to the negedge where EdgePulse is expected.
    task automatic step(input int gap);
        raise(gap);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ClkIn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        since = 1000;
        model_reset();
    endtask

    task automatic test_reset();
        bit ok;
        logic [CW+4:0] rv;
        rv = {1'b0, {CW{1'b0}}, 2'b11, 1'b0, 1'b0};
        bus.ClkIn = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (obs !== rv) begin
            bad++; $display("FAIL reset_values got=%h want=%h", obs, rv);
        end
        rst = 1'b0;
        model_reset();
        ok = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.EdgePulse !== 1'b0 || bus.Lost !== 1'b0) ok = 0;
        end
        total++;
        if (!ok) begin
            bad++; $display("FAIL idle_no_pulse_no_lost got=0 want=1");
        end
        total++;
        if (obs !== rv) begin
            bad++; $display("FAIL idle_outputs got=%h want=%h", obs, rv);
        end
    endtask

    task automatic test_slow_lock();
        int g[4] = '{10, PS, PS, PS};
        do_reset();
        foreach (g[i]) begin
            step(g[i]);
            total++;
            if (obs !== expv(1'b1)) begin
                bad++; $display("FAIL slow_lock edge%0d got=%h want=%h", i, obs, expv(1'b1));
            end
        end
        tick();
        total++;
        if (bus.EdgePulse !== 1'b0) begin
            bad++; $display("FAIL pulse_width got=%b want=0", bus.EdgePulse);
        end
    endtask

    task automatic test_fast();
        int g[4] = '{10, 103, 97, 100};
        do_reset();
        foreach (g[i]) begin
            step(g[i]);
            total++;
            if (obs !== expv(1'b1)) begin
                bad++; $display("FAIL fast edge%0d got=%h want=%h", i, obs, expv(1'b1));
            end
        end
    endtask

    task automatic test_switch();
        int g[5] = '{10, PS, PS, PF, PF};
        do_reset();
        foreach (g[i]) begin
            step(g[i]);
            total++;
            if (obs !== expv(1'b1)) begin
                bad++; $display("FAIL switch edge%0d got=%h want=%h", i, obs, expv(1'b1));
            end
        end
    endtask

    task automatic test_boundary();
        int g[11] = '{10, 300, 495, 505, 494, 506, 95, 105, 94, 500, 750};
        do_reset();
        foreach (g[i]) begin
            step(g[i]);
            total++;
            if (obs !== expv(1'b1)) begin
                bad++; $display("FAIL boundary gap%0d got=%h want=%h", g[i], obs, expv(1'b1));
            end
        end
    endtask

    task automatic test_loss();
        logic [CW+4:0] lv;
        do_reset();
        step(10); step(PS); step(PS);
        lv = {1'b0, m_period, 2'b11, 1'b0, 1'b1};
        while (since < TO + 2) tick();
        total++;
        if (bus.Lost !== 1'b0) begin
            bad++; $display("FAIL loss_early got=%b want=0", bus.Lost);
        end
        tick();
        total++;
        if (obs !== lv) begin
            bad++; $display("FAIL loss_state got=%h want=%h", obs, lv);
        end
        step(900);
        total++;
        if (obs !== expv(1'b1)) begin
            bad++; $display("FAIL loss_recover got=%h want=%h", obs, expv(1'b1));
        end
    endtask

    task automatic test_reset_mid();
        logic [CW+4:0] rv;
        rv = {1'b0, {CW{1'b0}}, 2'b11, 1'b0, 1'b0};
        do_reset();
        step(10); step(PS); step(PS);
        repeat (200) tick();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== rv) begin
            bad++; $display("FAIL reset_mid got=%h want=%h", obs, rv);
        end
        rst = 1'b0;
        model_reset();
        since = 1000;
        step(10); step(PS);
        total++;
        if (obs !== expv(1'b1)) begin
            bad++; $display("FAIL reset_prev_cleared got=%h want=%h", obs, expv(1'b1));
        end
    endtask

    task automatic test_random();
        int gap, prev_gap;
        do_reset();
        step(10);
        prev_gap = PS;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: gap = PS - 8 + int'($urandom_range(0, 16));
                1: gap = PF - 8 + int'($urandom_range(0, 16));
                2: gap = int'($urandom_range(60, 760));
                3: gap = prev_gap;
                default: gap = int'($urandom_range(740, 780));
            endcase
            prev_gap = gap;
            step(gap);
            total++;
            if (obs !== expv(1'b1)) begin
                bad++; $display("FAIL random i%0d gap%0d got=%h want=%h", i, gap, obs, expv(1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_slow_lock();
        test_fast();
        test_switch();
        test_boundary();
        test_loss();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
